// File: rtl/mem_map_pkg.sv
// Memory map shared by the access controller and anything else that decodes CPU addresses.
package mem_map_pkg;

  localparam logic [15:0] MAP_DATA_BASE    = 16'h0000;
  localparam logic [15:0] MAP_STACK_TOP    = 16'h0400;
  localparam logic [15:0] MAP_UART_BASE    = 16'h0800;
  localparam int          MAP_BLOCK_SIZE   = 32;
  localparam int          MAP_DATA_W       = 32;
  localparam int          MAP_UART_TIMEOUT = 255;

  typedef enum logic [1:0] {REG_DATA, REG_STACK, REG_UART, REG_NONE} region_e;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT_UART, S_RESP, S_FAULT} state_e;

endpackage

// File: rtl/addr_decode.sv
// Combinational region decode and physical word index for a 16-bit virtual address.
module addr_decode
  import mem_map_pkg::*;
#(
  parameter logic [15:0] DATA_BASE  = MAP_DATA_BASE,
  parameter logic [15:0] STACK_TOP  = MAP_STACK_TOP,
  parameter logic [15:0] UART_BASE  = MAP_UART_BASE,
  parameter int          BLOCK_SIZE = MAP_BLOCK_SIZE
) (
  input  logic [15:0]                   addr_i,
  output region_e                       region_o,
  output logic [$clog2(BLOCK_SIZE)-1:0] phys_o
);

  localparam int          PHYS_W = $clog2(BLOCK_SIZE);
  localparam logic [15:0] SIZE   = 16'(BLOCK_SIZE);

  // Wrapping 16-bit differences make each range check a single compare:
  // an address below an ascending base (or above the stack top) wraps to a large value.
  always_comb begin
    region_o = REG_NONE;
    phys_o   = '0;
    if ((addr_i - DATA_BASE) < SIZE) begin
      region_o = REG_DATA;
      phys_o   = PHYS_W'(addr_i - DATA_BASE);
    end else if ((STACK_TOP - addr_i) < SIZE) begin
      region_o = REG_STACK;
      phys_o   = PHYS_W'(STACK_TOP - addr_i);
    end else if ((addr_i - UART_BASE) < SIZE) begin
      region_o = REG_UART;
      phys_o   = PHYS_W'(addr_i - UART_BASE);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences CPU loads/stores onto data RAM, stack RAM and UART with a busy/done handshake,
// bounded UART back-pressure wait and fault reporting.
module mem_access_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [15:0] DATA_BASE    = MAP_DATA_BASE,
  parameter logic [15:0] STACK_TOP    = MAP_STACK_TOP,
  parameter logic [15:0] UART_BASE    = MAP_UART_BASE,
  parameter int          BLOCK_SIZE   = MAP_BLOCK_SIZE,
  parameter int          DATA_W       = MAP_DATA_W,
  parameter int          UART_TIMEOUT = MAP_UART_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [15:0]                   cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_busy,
  output logic                          cpu_done,
  output logic                          cpu_fault,
  output logic                          data_en,
  output logic                          stack_en,
  output logic                          uart_en,
  output logic                          mem_we,
  output logic [$clog2(BLOCK_SIZE)-1:0] phys_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             data_rdata,
  input  logic [DATA_W-1:0]             stack_rdata,
  input  logic [DATA_W-1:0]             uart_rdata,
  input  logic                          uartfull
);

  localparam int PHYS_W = $clog2(BLOCK_SIZE);
  localparam int CNT_W  = $clog2(UART_TIMEOUT + 1);

  state_e              state_q;
  logic [15:0]         addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                done_q;
  logic                fault_q;
  logic [CNT_W-1:0]    cnt_q;

  region_e             region;
  logic [PHYS_W-1:0]   phys;
  logic                data_en_c;
  logic                stack_en_c;
  logic                uart_en_c;
  logic                any_en;

  addr_decode #(
    .DATA_BASE  (DATA_BASE),
    .STACK_TOP  (STACK_TOP),
    .UART_BASE  (UART_BASE),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_addr_decode (
    .addr_i   (addr_q),
    .region_o (region),
    .phys_o   (phys)
  );

  // Enables follow uartfull within the cycle so a UART store fires as soon as space appears.
  always_comb begin
    data_en_c  = 1'b0;
    stack_en_c = 1'b0;
    uart_en_c  = 1'b0;
    if (state_q == S_ACCESS) begin
      case (region)
        REG_DATA:  data_en_c  = 1'b1;
        REG_STACK: stack_en_c = 1'b1;
        REG_UART:  uart_en_c  = !(we_q && uartfull);
        default:   ;
      endcase
    end else if (state_q == S_WAIT_UART) begin
      uart_en_c = !uartfull;
    end
  end

  assign any_en    = data_en_c | stack_en_c | uart_en_c;
  assign data_en   = data_en_c;
  assign stack_en  = stack_en_c;
  assign uart_en   = uart_en_c;
  assign mem_we    = any_en & we_q;
  assign phys_addr = any_en ? phys : '0;
  assign mem_wdata = any_en ? wdata_q : '0;
  assign cpu_busy  = (state_q != S_IDLE);
  assign cpu_done  = done_q;
  assign cpu_fault = fault_q;
  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (region == REG_NONE) begin
            state_q <= S_FAULT;
          end else if (region == REG_UART && we_q && uartfull) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_UART;
          end else begin
            state_q <= S_RESP;
          end
        end
        S_WAIT_UART: begin
          cnt_q <= cnt_q + 1'b1;
          if (!uartfull) begin
            state_q <= S_RESP;
          end else if (cnt_q == CNT_W'(UART_TIMEOUT - 1)) begin
            state_q <= S_FAULT;
          end
        end
        S_RESP: begin
          if (!we_q) begin
            case (region)
              REG_DATA:  rdata_q <= data_rdata;
              REG_STACK: rdata_q <= stack_rdata;
              REG_UART:  rdata_q <= uart_rdata;
              default:   ;
            endcase
          end
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          done_q  <= 1'b1;
          fault_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
